// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and helpers for the
// sequential binary-to-BCD display driver.
package bcd_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    // Largest value that fits in d decimal digits.
    function automatic int pow10_minus1(input int d);
        int p;
        p = 1;
        for (int i = 0; i < d; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: one double-dabble digit
// correction, adds 3 when the digit is >= 5.
module bcd_digit_adjust (
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    // Pre-shift correction so the doubled digit
    // carries into the next decade.
    always_comb begin
        d_out = d_in;
        if (d_in >= 4'd5) begin
            d_out = d_in + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_display_driver.sv
// bcd_display_driver: clamps a signed result and
// converts it to registered BCD digits and flags.
module bcd_display_driver
    import bcd_pkg::*;
#(
    parameter int IN_WIDTH = 32,
    parameter int DIGITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [4*DIGITS-1:0]   digits_out,
    output logic [DIGITS-1:0]     blank_out,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  valid_out
);

    localparam int MAXV = pow10_minus1(DIGITS);
    localparam int SHIFT_BITS = $clog2(MAXV + 1);
    localparam int CW = $clog2(SHIFT_BITS + 1);
    localparam int DW = 4 * DIGITS;

    state_t                 state;
    state_t                 state_nxt;
    logic [SHIFT_BITS-1:0]  bin_q;
    logic [SHIFT_BITS-1:0]  bin_nxt;
    logic [SHIFT_BITS-1:0]  load_val;
    logic [DW-1:0]          scr_q;
    logic [DW-1:0]          scr_adj;
    logic [DW-1:0]          scr_nxt;
    logic [CW-1:0]          cnt_q;
    logic                   pend_ovf;
    logic                   pend_udf;
    logic                   accept;
    logic                   last;
    logic                   is_neg;
    logic                   is_big;
    logic [DIGITS-1:0]      blank_nxt;

    assign accept = valid_in && ready_in;
    assign last   = (state == SHIFT) &&
                    (cnt_q == CW'(SHIFT_BITS - 1));

    assign is_neg = data_in[IN_WIDTH-1];
    assign is_big = $signed(data_in) >
                    $signed(IN_WIDTH'(MAXV));

    // Clamp the incoming value into the
    // displayable range before loading.
    always_comb begin
        load_val = data_in[SHIFT_BITS-1:0];
        if (is_neg) begin
            load_val = '0;
        end else if (is_big) begin
            load_val = SHIFT_BITS'(MAXV);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .d_in  (scr_q[4*g +: 4]),
            .d_out (scr_adj[4*g +: 4])
        );
    end

    assign {scr_nxt, bin_nxt} = {scr_adj, bin_q} << 1;

    // A digit blanks only when it and every
    // higher digit are zero; ones never blanks.
    always_comb begin
        logic       zero_above;
        bcd_digit_t d;
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            d = scr_nxt[4*i +: 4];
            zero_above = zero_above && (d == 4'd0);
            blank_nxt[i] = zero_above;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: run SHIFT_BITS shifts per value.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake output decoded from state.
    always_comb begin
        ready_in = 1'b0;
        if (state == IDLE) begin
            ready_in = 1'b1;
        end
    end

    // Shift datapath and result registers; the
    // previous result holds until completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q      <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            pend_ovf   <= 1'b0;
            pend_udf   <= 1'b0;
            digits_out <= '0;
            blank_out  <= ~DIGITS'(1);
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            valid_out  <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (accept) begin
                bin_q    <= load_val;
                scr_q    <= '0;
                cnt_q    <= '0;
                pend_ovf <= is_big;
                pend_udf <= is_neg;
            end else if (state == SHIFT) begin
                bin_q <= bin_nxt;
                scr_q <= scr_nxt;
                cnt_q <= cnt_q + CW'(1);
                if (last) begin
                    digits_out <= scr_nxt;
                    blank_out  <= blank_nxt;
                    overflow   <= pend_ovf;
                    underflow  <= pend_udf;
                    valid_out  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver: directed vectors, corner
// sequences and a reference-model sweep.
module tb_bcd_display_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_in;
    logic [11:0] digits_out;
    logic [2:0]  blank_out;
    logic        overflow;
    logic        underflow;
    logic        valid_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic signed [31:0] din;
        logic [11:0]        dig;
        logic [2:0]         blk;
        logic               ovf;
        logic               udf;
    } vec_t;

    vec_t vecs[8];

    bcd_display_driver #(
        .IN_WIDTH (32),
        .DIGITS   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .digits_out (digits_out),
        .blank_out  (blank_out),
        .overflow   (overflow),
        .underflow  (underflow),
        .valid_out  (valid_out)
    );

    always #5 clk = ~clk;

    function automatic void chk(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endfunction

    function automatic vec_t model(
        input logic signed [31:0] v
    );
        vec_t m;
        int   c;
        if (v < 0) c = 0;
        else if (v > 999) c = 999;
        else c = v;
        m.din = v;
        m.dig = {4'(c / 100), 4'((c / 10) % 10),
                 4'(c % 10)};
        m.blk = {c < 100, c < 10, 1'b0};
        m.ovf = (v > 999);
        m.udf = (v < 0);
        return m;
    endfunction

    task automatic convert(
        input  logic [31:0] v,
        output int          lat,
        output logic        stable
    );
        int          n;
        logic [11:0] d0;
        n = 0;
        @(negedge clk);
        while (!ready_in && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(ready_in), 32'd1);
        d0       = digits_out;
        data_in  = v;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        data_in  = ~v;
        chk("ready_low", 32'(ready_in), 32'd0);
        lat    = 0;
        stable = 1'b1;
        while (!valid_out && lat < 40) begin
            if (digits_out !== d0) stable = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_res(input vec_t e);
        chk("digits", 32'(digits_out), 32'(e.dig));
        chk("blank", 32'(blank_out), 32'(e.blk));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("underflow", 32'(underflow), 32'(e.udf));
    endtask

    task automatic check_reset_vals();
        chk("rst_digits", 32'(digits_out), 32'h0);
        chk("rst_blank", 32'(blank_out), 32'b110);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_udf", 32'(underflow), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_ready", 32'(ready_in), 32'd1);
    endtask

    initial begin
        int          lat;
        logic        stable;
        int          acc;
        int          a0;
        int          a1;
        int          np;
        int          pulses;
        logic [11:0] res[2];
        vec_t        e;

        vecs[0] = '{32'sd124, 12'h124, 3'b000, 0, 0};
        vecs[1] = '{32'sd0, 12'h000, 3'b110, 0, 0};
        vecs[2] = '{32'sd7, 12'h007, 3'b110, 0, 0};
        vecs[3] = '{32'sd82, 12'h082, 3'b100, 0, 0};
        vecs[4] = '{32'sd999, 12'h999, 3'b000, 0, 0};
        vecs[5] = '{32'sd1000, 12'h999, 3'b000, 1, 0};
        vecs[6] = '{-32'sd5, 12'h000, 3'b110, 0, 1};
        vecs[7] = '{32'sh8000_0000, 12'h000, 3'b110,
                    0, 1};

        rst      = 1'b1;
        data_in  = '0;
        valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            convert(vecs[i].din, lat, stable);
            chk("latency", 32'(lat), 32'd10);
            chk("hold_stable", 32'(stable), 32'd1);
            check_res(vecs[i]);
            @(posedge clk);
            #1;
            chk("pulse_width", 32'(valid_out), 32'd0);
        end

        // Back-to-back with valid held high.
        @(negedge clk);
        data_in  = 32'd124;
        valid_in = 1'b1;
        acc = 0;
        a0  = 0;
        a1  = 0;
        np  = 0;
        for (int c = 0; c < 30; c++) begin
            if (acc == 2) valid_in = 1'b0;
            if (valid_out) begin
                if (np < 2) res[np] = digits_out;
                np++;
            end
            if (ready_in && valid_in) begin
                if (acc == 0) a0 = c;
                else a1 = c;
                acc++;
            end
            if (acc == 1 && c == a0 + 1) data_in = 32'd555;
            if (acc == 1 && c == a0 + 5) data_in = 32'd82;
            @(negedge clk);
        end
        chk("b2b_accepts", 32'(acc), 32'd2);
        chk("b2b_spacing", 32'(a1 - a0), 32'd11);
        chk("b2b_pulses", 32'(np), 32'd2);
        chk("b2b_res0", 32'(res[0]), 32'h124);
        chk("b2b_res1", 32'(res[1]), 32'h082);

        // Reset in the middle of a conversion.
        @(negedge clk);
        data_in  = 32'd124;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (valid_out) pulses++;
        end
        chk("rst_no_pulse", 32'(pulses), 32'd0);
        convert(32'd82, lat, stable);
        chk("post_rst_lat", 32'(lat), 32'd10);
        check_res(vecs[3]);

        // Sweep against the reference model.
        for (int v = 0; v < 1024; v++) begin
            convert(32'(v), lat, stable);
            chk("sweep_lat", 32'(lat), 32'd10);
            e = model(32'(v));
            check_res(e);
        end
        for (int k = 0; k < 20; k++) begin
            int r;
            r = -int'($urandom_range(1, 32'h7fff_ffff));
            convert(32'(r), lat, stable);
            e = model(32'(r));
            check_res(e);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
